// File: rtl/rv_mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Included by the picker, the interface users and the top.
package rv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

endpackage

// File: rtl/rv_mem_arb_if.sv
// Bus bundle for rv_mem_arb: core port, loader port, memory port.
// slave = arbiter side, master = requesters/memory side.
interface rv_mem_arb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          c_req;
    logic          c_we;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;
    logic [DW-1:0] c_rdata;
    logic          c_done;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;

    logic          m_en;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    logic          busy;
    logic          owner;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  d_req, d_we, d_addr, d_wdata,
        input  m_rdata,
        output c_rdata, c_done, d_rdata, d_done,
        output m_en, m_we, m_addr, m_wdata,
        output busy, owner
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output d_req, d_we, d_addr, d_wdata,
        output m_rdata,
        input  c_rdata, c_done, d_rdata, d_done,
        input  m_en, m_we, m_addr, m_wdata,
        input  busy, owner
    );

endinterface

// File: rtl/rv_arb_pick.sv
// Combinational 2-way request picker (round-robin on ties).
// RV_MEM_ARB_CORE_PRIO_EN: core always wins a tie instead.
module rv_arb_pick
    import rv_mem_arb_pkg::*;
(
    input  logic c_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

    logic tie_id;

`ifdef RV_MEM_ARB_CORE_PRIO_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
    assign tie_id = OWN_CORE;
`else
    assign tie_id = ~last_owner;
`endif

    // select the winner among the present requests
    always_comb begin
        grant_valid = c_req | d_req;
        grant_id    = OWN_CORE;
        unique case (1'b1)
            (c_req & d_req):  grant_id = tie_id;
            (d_req & ~c_req): grant_id = OWN_DMA;
            default:          grant_id = OWN_CORE;
        endcase
    end

endmodule

// File: rtl/rv_mem_arb.sv
// Single-port memory arbiter: core vs loader, whole-transaction grants.
// Build option: RV_MEM_ARB_CORE_PRIO_EN selects fixed core priority.
module rv_mem_arb
    import rv_mem_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input logic         clk,
    input logic         rst,
    rv_mem_arb_if.slave bus
);

    localparam int CW = $clog2(MEM_LAT + 1) + 1;

    arb_state_t    state;
    arb_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic          cap;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          owner_q;
    logic          last_owner;
    logic [DW-1:0] c_rdata_q;
    logic [DW-1:0] d_rdata_q;
    logic          grant_valid;
    logic          grant_id;

    rv_arb_pick u_pick (
        .c_req       (bus.c_req),
        .d_req       (bus.d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state and read-capture strobe
    always_comb begin
        state_nxt = state;
        cap       = 1'b0;
        unique case (state)
            IDLE:  if (grant_valid) state_nxt = ISSUE;
            ISSUE: state_nxt = cmd_we ? RESP : WAIT;
            WAIT: begin
                if (cnt == CW'(MEM_LAT)) begin
                    cap       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // latch the winner's command; counter reads 1 on the first WAIT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            owner_q    <= OWN_CORE;
            last_owner <= OWN_DMA;
            cnt        <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                cmd_we     <= grant_id ? bus.d_we    : bus.c_we;
                cmd_addr   <= grant_id ? bus.d_addr  : bus.c_addr;
                cmd_wdata  <= grant_id ? bus.d_wdata : bus.c_wdata;
                owner_q    <= grant_id;
                last_owner <= grant_id;
            end
            if (state == ISSUE)
                cnt <= CW'(1);
            else if (state == WAIT && !cap)
                cnt <= cnt + 1'b1;
        end
    end

    // capture read data into the owner's register only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (cap) begin
            if (owner_q == OWN_DMA) d_rdata_q <= bus.m_rdata;
            else                    c_rdata_q <= bus.m_rdata;
        end
    end

    assign bus.m_en    = (state == ISSUE);
    assign bus.m_we    = (state == ISSUE) & cmd_we;
    assign bus.m_addr  = cmd_addr;
    assign bus.m_wdata = cmd_wdata;
    assign bus.c_done  = (state == RESP) & (owner_q == OWN_CORE);
    assign bus.d_done  = (state == RESP) & (owner_q == OWN_DMA);
    assign bus.c_rdata = c_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state != IDLE);
    assign bus.owner   = owner_q;

endmodule

// File: tb/tb_rv_mem_arb.sv
// Self-checking bench for rv_mem_arb (MEM_LAT=1 and MEM_LAT=3 instances).
// Vector table + scoreboard queue, plus hand sequences for corner cases.
module tb_rv_mem_arb;
    import rv_mem_arb_pkg::*;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_c;
        logic [31:0] exp_d;
        int          start;
    } sb_t;

    logic clk = 1'b0;
    logic rst1;
    logic rst3;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    int   mcnt = 0;
    bit   sb_on = 1'b0;
    sb_t  sbq[$];
    vec_t vt[9];
    logic [31:0] mdl_c;
    logic [31:0] mdl_d;
    logic [2:0]  exp_ord;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] p1;
    logic [31:0] q0, q1, q2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rv_mem_arb_if #(.AW(32), .DW(32)) b1 ();
    rv_mem_arb_if #(.AW(32), .DW(32)) b3 ();

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(1)) u1 (
        .clk (clk),
        .rst (rst1),
        .bus (b1.slave)
    );

    rv_mem_arb #(.AW(32), .DW(32), .MEM_LAT(3)) u3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3.slave)
    );

    // memory model, latency 1
    always @(posedge clk) begin
        if (rst1) begin
            for (int i = 0; i < 64; i++) mem1[i] <= 32'h100 + 32'(i);
            mem1[4] <= 32'hDEADBEEF;
        end else if (b1.m_en && b1.m_we) begin
            mem1[b1.m_addr[7:2]] <= b1.m_wdata;
        end
        p1 <= (b1.m_en && !b1.m_we) ? mem1[b1.m_addr[7:2]] : 32'hBAD0_0001;
    end
    assign b1.m_rdata = p1;

    // memory model, latency 3, junk on the bus until the data is due
    always @(posedge clk) begin
        if (rst3) begin
            for (int i = 0; i < 64; i++) mem3[i] <= 32'h300 + 32'(i);
            mem3[4] <= 32'h11112222;
            mem3[8] <= 32'h33334444;
        end else if (b3.m_en && b3.m_we) begin
            mem3[b3.m_addr[7:2]] <= b3.m_wdata;
        end
        q0 <= (b3.m_en && !b3.m_we) ? mem3[b3.m_addr[7:2]] : 32'hBAD0_0003;
        q1 <= q0;
        q2 <= q1;
    end
    assign b3.m_rdata = q2;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got timeout expected done", nm);
    endtask

    task automatic chk_rst(input string nm, input logic en, input logic we,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic cd, input logic dd,
                           input logic [31:0] cr, input logic [31:0] dr,
                           input logic bz, input logic ow);
        chk({nm, "_m_en"}, 32'(en), 0);
        chk({nm, "_m_we"}, 32'(we), 0);
        chk({nm, "_m_addr"}, a, 0);
        chk({nm, "_m_wdata"}, wd, 0);
        chk({nm, "_dones"}, 32'({cd, dd}), 0);
        chk({nm, "_c_rdata"}, cr, 0);
        chk({nm, "_d_rdata"}, dr, 0);
        chk({nm, "_busy"}, 32'(bz), 0);
        chk({nm, "_owner"}, 32'(ow), 0);
    endtask

    // scoreboard monitor for the latency-1 instance
    always @(negedge clk) begin : mon
        sb_t e;
        if (!sb_on) mcnt = 0;
        if (!rst1 && (b1.c_done || b1.d_done))
            chk("one_done", 32'(b1.c_done & b1.d_done), 0);
        if (!rst1 && sb_on && b1.m_en) begin
            mcnt++;
            if (sbq.size() == 0) begin
                tmo("spurious_m_en");
            end else begin
                chk("m_we", 32'(b1.m_we), 32'(sbq[0].we));
                chk("m_addr", b1.m_addr, sbq[0].addr);
                if (sbq[0].we) chk("m_wdata", b1.m_wdata, sbq[0].wdata);
            end
        end
        if (!rst1 && sb_on && (b1.c_done || b1.d_done)) begin
            if (sbq.size() == 0) begin
                tmo("spurious_done");
            end else begin
                e = sbq.pop_front();
                chk("done_port", 32'(b1.d_done), 32'(e.port));
                chk("owner", 32'(b1.owner), 32'(e.port));
                chk("latency", 32'(cyc - e.start), e.we ? 32'd2 : 32'd3);
                chk("m_en_count", 32'(mcnt), 1);
                chk("c_rdata", b1.c_rdata, e.exp_c);
                chk("d_rdata", b1.d_rdata, e.exp_d);
                mcnt = 0;
            end
        end
    end

    task automatic run_vec(input vec_t v);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        if (!v.we) begin
            if (v.port) mdl_d = v.rdata;
            else        mdl_c = v.rdata;
        end
        sbq.push_back('{v.port, v.we, v.addr, v.wdata, mdl_c, mdl_d, cyc});
        if (v.port) begin
            b1.d_req = 1'b1; b1.d_we = v.we;
            b1.d_addr = v.addr; b1.d_wdata = v.wdata;
        end else begin
            b1.c_req = 1'b1; b1.c_we = v.we;
            b1.c_addr = v.addr; b1.c_wdata = v.wdata;
        end
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = v.port ? b1.d_done : b1.c_done;
        end
        if (!seen) tmo("vec_done");
        b1.c_req = 1'b0;
        b1.d_req = 1'b0;
    endtask

    initial begin
        bit seen;
        int got;
        int n3;

        b1.c_req = 0; b1.c_we = 0; b1.c_addr = 0; b1.c_wdata = 0;
        b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
        b3.c_req = 0; b3.c_we = 0; b3.c_addr = 0; b3.c_wdata = 0;
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = 0; b3.d_wdata = 0;
        rst1 = 1'b1;
        rst3 = 1'b1;
        mdl_c = 0;
        mdl_d = 0;

        vt[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        vt[1] = '{1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h40, 32'h0, 32'h12345678};
        vt[3] = '{1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0};
        vt[4] = '{1'b0, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D};
        vt[5] = '{1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        vt[6] = '{1'b0, 1'b0, 32'h08, 32'h0, 32'h00000102};
        vt[7] = '{1'b1, 1'b1, 32'h3C, 32'hA5A5A5A5, 32'h0};
        vt[8] = '{1'b1, 1'b0, 32'h3C, 32'h0, 32'hA5A5A5A5};

        repeat (3) @(negedge clk);
        chk_rst("rst1", b1.m_en, b1.m_we, b1.m_addr, b1.m_wdata, b1.c_done,
                b1.d_done, b1.c_rdata, b1.d_rdata, b1.busy, b1.owner);
        chk_rst("rst3", b3.m_en, b3.m_we, b3.m_addr, b3.m_wdata, b3.c_done,
                b3.d_done, b3.c_rdata, b3.d_rdata, b3.busy, b3.owner);
        @(negedge clk);
        rst1 = 1'b0;
        rst3 = 1'b0;
        repeat (2) @(negedge clk);

        // table-driven single transactions on the latency-1 instance
        sb_on = 1'b1;
        for (int i = 0; i < 9; i++) run_vec(vt[i]);
        repeat (2) @(negedge clk);
        chk("sb_empty", 32'(sbq.size()), 0);
        sb_on = 1'b0;

        // both requesting from reset, both held for three grants
`ifdef RV_MEM_ARB_CORE_PRIO_EN
        exp_ord = 3'b000;
`else
        exp_ord = 3'b010;
`endif
        @(negedge clk);
        rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        b1.c_req = 1; b1.c_we = 0; b1.c_addr = 32'h10;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 32'h08;
        got = 0;
        for (int k = 0; k < 40 && got < 3; k++) begin
            @(negedge clk);
            if (b1.c_done || b1.d_done) begin
                chk("rr_owner", 32'(b1.owner), 32'(exp_ord[got]));
                chk("rr_port", 32'(b1.d_done), 32'(exp_ord[got]));
                got++;
                if (got == 3) begin
                    b1.c_req = 0;
                    b1.d_req = 0;
                end
            end
        end
        if (got < 3) tmo("rr_grants");
        b1.c_req = 0;
        b1.d_req = 0;
        repeat (2) @(negedge clk);
        chk("rr_c_rdata", b1.c_rdata, 32'hDEADBEEF);
`ifdef RV_MEM_ARB_CORE_PRIO_EN
        chk("rr_d_rdata", b1.d_rdata, 32'h0);
`else
        chk("rr_d_rdata", b1.d_rdata, 32'h102);
`endif

        // latency-3 read with an address change while waiting
        @(negedge clk);
        b3.c_req = 1; b3.c_we = 0; b3.c_addr = 32'h10;
        seen = 0;
        n3 = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (b3.m_en) begin
                n3++;
                chk("l3_men_cycle", 32'(k), 1);
                chk("l3_m_we", 32'(b3.m_we), 0);
            end
            if (k == 3) b3.c_addr = 32'h20;
            if (k == 4) begin
                chk("l3_m_addr_held", b3.m_addr, 32'h10);
                chk("l3_no_early_cap", b3.c_rdata, 32'h0);
            end
            if (b3.c_done) begin
                seen = 1;
                chk("l3_latency", 32'(k), 5);
                chk("l3_c_rdata", b3.c_rdata, 32'h11112222);
                chk("l3_d_rdata", b3.d_rdata, 32'h0);
                chk("l3_men_count", 32'(n3), 1);
            end
        end
        if (!seen) tmo("l3_done");
        b3.c_req = 0;

        // reset asserted in WAIT aborts the transaction
        @(negedge clk);
        b3.c_req = 1; b3.c_we = 0; b3.c_addr = 32'h20;
        repeat (3) @(negedge clk);
        chk("ab_busy_before", 32'(b3.busy), 1);
        rst3 = 1'b1;
        b3.c_req = 0;
        #1;
        chk_rst("ab", b3.m_en, b3.m_we, b3.m_addr, b3.m_wdata, b3.c_done,
                b3.d_done, b3.c_rdata, b3.d_rdata, b3.busy, b3.owner);
        @(negedge clk);
        rst3 = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("ab_quiet", 32'({b3.c_done, b3.d_done, b3.m_en}), 0);
        end

        // first request after reset is served normally
        b3.d_req = 1; b3.d_we = 0; b3.d_addr = 32'h20;
        seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (b3.d_done) begin
                seen = 1;
                chk("pr_latency", 32'(k), 5);
                chk("pr_owner", 32'(b3.owner), 1);
                chk("pr_d_rdata", b3.d_rdata, 32'h33334444);
                chk("pr_c_rdata", b3.c_rdata, 32'h0);
            end
        end
        if (!seen) tmo("pr_done");
        b3.d_req = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rv_mem_arb.md
Name: rv_mem_arb

Overview:
- Arbitrates one single-ported instruction/data memory between two requesters.
  - Core port (c_*): driven by the multicycle control FSM's fetch/load/store sequencing.
  - Loader/DMA port (d_*): external program loader or debug access.
- Each access is a whole transaction: grant, issue, wait for fixed read latency, respond.
- Grant is held until the response; round-robin between requesters.
- Sits between the core control/datapath and the memory macro.

Parameters:
- AW, 32, address width in bits (byte address, passed through unchanged).
- DW, 32, data width.
- MEM_LAT, 1, memory read latency in cycles, ≥1. m_rdata is valid MEM_LAT cycles after the m_en cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- c_req  in  1  core request; held until c_done.
- c_we  in  1  core write (1) / read (0).
- c_addr  in  AW  core address.
- c_wdata  in  DW  core write data.
- c_rdata  out  DW  core read data, registered; valid from c_done onward.
- c_done  out  1  one-cycle completion pulse to core.
- d_req, d_we, d_addr, d_wdata  in  1/1/AW/DW  loader port, same meaning as core.
- d_rdata  out  DW  loader read data, registered.
- d_done  out  1  one-cycle completion pulse to loader.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write enable; valid only with m_en.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data.
- busy  out  1  high in any state other than IDLE.
- owner  out  1  current or last grantee; 0 = core, 1 = loader.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any request is present, pick a winner, latch its we/addr/wdata into the command registers, set owner, go to ISSUE.
  - If no request, stay in IDLE.
- ISSUE: m_en=1, m_we=cmd_we, m_addr/m_wdata from the command registers.
  - Write: go to RESP.
  - Read: clear the counter, go to WAIT.
- WAIT:
  - Counter increments every cycle, starting at 1 on the first WAIT cycle.
  - When cnt==MEM_LAT: capture m_rdata into the owner's rdata register (the other rdata register is unchanged), go to RESP.
- RESP: pulse owner's done for one cycle, go to IDLE.
- Latency, measured from the IDLE cycle in which the request is sampled (cycle T):
  - Read: done at T+2+MEM_LAT.
  - Write: done at T+2.
- Arbitration in IDLE:
  - Only one request present: it wins.
  - Both present: the requester that is not last_owner wins.
  - last_owner updates on every grant.
- Handshake:
  - Requester holds req/we/addr/wdata stable until done.
  - Changes after the grant cycle are ignored; the command is already latched.
  - A req still high in the cycle after done is treated as a new request.
- Reset values: state=IDLE, m_en=0, m_we=0, m_addr=0, m_wdata=0, c_done=d_done=0, c_rdata=d_rdata=0, busy=0, owner=0, last_owner=1 (core wins the first tie), cnt=0.
- Reset mid-transaction: abort immediately.
  - No done pulse is issued.
  - An in-flight read result is discarded.
  - The memory sees no further strobe.
- Outside ISSUE: m_en=0 and m_we=0. m_addr/m_wdata hold the command registers (no glitching to zero).
- Never two m_en in one transaction; never both done outputs in the same cycle.

Optional Feature:
- RV_MEM_ARB_CORE_PRIO_EN defined: fixed priority. The core always wins a tie; last_owner is ignored for selection but owner still reports the grantee.
- Not defined: round-robin as above.

Decomposition:
- Package rv_mem_arb_pkg:
  - arb_state_t enum (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
  - Owner constants OWN_CORE=1'b0, OWN_DMA=1'b1.
- One natural sub-module: rv_arb_pick. It is a combinational 2-way picker with inputs c_req, d_req, last_owner, and outputs grant_valid and grant_id. The priority macro is resolved inside it.
- Counter and FSM stay in rv_mem_arb.

Test Plan:
- Core read, MEM_LAT=1, c_addr=0x10, memory returns 0xDEADBEEF → single m_en at T+1 with m_we=0, c_done at T+3, c_rdata=0xDEADBEEF, d_done never asserted.
- Loader write, d_addr=0x40, d_wdata=0x12345678 → m_en=1 and m_we=1 at T+1 with the correct addr/data, d_done at T+2, d_rdata unchanged.
- Both req at the same cycle after reset, then both held → grants in order core, loader, core; owner toggles accordingly. With RV_MEM_ARB_CORE_PRIO_EN defined, the order is core, core, core.
- MEM_LAT=3 core read → c_done at T+5; a change of m_rdata before the capture cycle is not captured.
- rst asserted during WAIT → all outputs return to reset values asynchronously, no done pulse. After release, the first new request is served normally.
- c_addr changed during WAIT → m_addr keeps the latched value; returned data corresponds to the original address.
